// File: rtl/csr_counter_read_unit_if.sv
// Request/response bundle between the CSR decode/write-mux side and the
// counter read unit.
interface csr_counter_read_unit_if;
  logic [11:0] csr_addr_in;
  logic        csr_rd_en_in;
  logic        csr_wr_en_in;
  logic [31:0] data_wr_in;
  logic        instret_inc_in;
  logic [31:0] csr_data_out;
  logic        csr_rd_valid_out;
  logic        illegal_addr_out;

  modport master (
    output csr_addr_in, csr_rd_en_in, csr_wr_en_in, data_wr_in, instret_inc_in,
    input  csr_data_out, csr_rd_valid_out, illegal_addr_out
  );

  modport slave (
    input  csr_addr_in, csr_rd_en_in, csr_wr_en_in, data_wr_in, instret_inc_in,
    output csr_data_out, csr_rd_valid_out, illegal_addr_out
  );
endinterface

// File: rtl/csr_counter_read_unit.sv
// Holds mcycle, minstret and mcountinhibit and serves one-cycle-latency
// registered reads of them (and their user read-only shadows).
module csr_counter_read_unit #(
  parameter logic [2:0] INHIBIT_RESET        = 3'b000,
  parameter bit         ENABLE_USER_COUNTERS = 1'b1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  csr_counter_read_unit_if.slave bus
);
  localparam int         NUM_CNT      = 2;
  localparam logic [2:0] INHIBIT_MASK = 3'b101;

  logic [63:0]        cnt_val [NUM_CNT];
  logic [NUM_CNT-1:0] cnt_inc;
  logic [2:0]         inhibit_reg, inhibit_next;
  logic [31:0]        data_reg, data_next;
  logic               valid_reg, illegal_reg;
  logic               hit, user_ro, access, illegal, wr_ok;
  logic [31:0]        rd_val;

  always_comb begin
    hit     = 1'b1;
    user_ro = 1'b0;
    rd_val  = '0;
    case (bus.csr_addr_in)
      12'hB00: rd_val = cnt_val[0][31:0];
      12'hB80: rd_val = cnt_val[0][63:32];
      12'hB02: rd_val = cnt_val[1][31:0];
      12'hB82: rd_val = cnt_val[1][63:32];
      12'h320: rd_val = {29'd0, inhibit_reg};
      12'hC00, 12'hC01: begin user_ro = 1'b1; rd_val = cnt_val[0][31:0];  end
      12'hC80, 12'hC81: begin user_ro = 1'b1; rd_val = cnt_val[0][63:32]; end
      12'hC02:          begin user_ro = 1'b1; rd_val = cnt_val[1][31:0];  end
      12'hC82:          begin user_ro = 1'b1; rd_val = cnt_val[1][63:32]; end
      default: hit = 1'b0;
    endcase
    if (user_ro && !ENABLE_USER_COUNTERS) hit = 1'b0;
  end

  assign access  = bus.csr_rd_en_in | bus.csr_wr_en_in;
  assign illegal = access & (~hit | (bus.csr_wr_en_in & user_ro));
  assign wr_ok   = bus.csr_wr_en_in & ~illegal;

  // Increments always use the inhibit value in force this cycle.
  assign cnt_inc[0] = ~inhibit_reg[0];
  assign cnt_inc[1] = bus.instret_inc_in & ~inhibit_reg[2];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      localparam logic [11:0] LO_ADDR = (gi == 0) ? 12'hB00 : 12'hB02;
      localparam logic [11:0] HI_ADDR = LO_ADDR | 12'h080;

      logic [63:0] cnt_reg, cnt_next;
      logic        wr_lo, wr_hi;

      assign wr_lo = wr_ok && (bus.csr_addr_in == LO_ADDR);
      assign wr_hi = wr_ok && (bus.csr_addr_in == HI_ADDR);

      // A high-half write keeps the low half counting but drops its carry.
      always_comb begin
        if (wr_lo)
          cnt_next = {cnt_reg[63:32], bus.data_wr_in};
        else if (wr_hi)
          cnt_next = {bus.data_wr_in, cnt_reg[31:0] + {31'd0, cnt_inc[gi]}};
        else
          cnt_next = cnt_reg + {63'd0, cnt_inc[gi]};
      end

      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) cnt_reg <= '0;
        else        cnt_reg <= cnt_next;
      end

      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  always_comb begin
    inhibit_next = inhibit_reg;
    if (wr_ok && bus.csr_addr_in == 12'h320)
      inhibit_next = bus.data_wr_in[2:0] & INHIBIT_MASK;
    data_next = data_reg;
    if (bus.csr_rd_en_in)
      data_next = illegal ? 32'd0 : rd_val;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      inhibit_reg <= INHIBIT_RESET & INHIBIT_MASK;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      inhibit_reg <= inhibit_next;
      data_reg    <= data_next;
      valid_reg   <= bus.csr_rd_en_in;
      illegal_reg <= illegal;
    end
  end

  assign bus.csr_data_out     = data_reg;
  assign bus.csr_rd_valid_out = valid_reg;
  assign bus.illegal_addr_out = illegal_reg;
endmodule

// File: tb/tb_csr_counter_read_unit.sv
// Directed scoreboard bench for csr_counter_read_unit: expectations are pushed
// when a request is driven and popped after the next rising edge.
module tb_csr_counter_read_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  csr_counter_read_unit_if bus();

  csr_counter_read_unit dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m_cyc = '0;
  logic [63:0] m_ins = '0;
  logic [2:0]  m_inh = 3'b000;
  logic [31:0] m_dout = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic void tb_decode(input logic [11:0] a, output bit hit, output bit ro,
                                    output logic [31:0] val);
    hit = 1'b1; ro = 1'b0; val = '0;
    case (a)
      12'hB00: val = m_cyc[31:0];
      12'hB80: val = m_cyc[63:32];
      12'hB02: val = m_ins[31:0];
      12'hB82: val = m_ins[63:32];
      12'h320: val = {29'd0, m_inh};
      12'hC00, 12'hC01: begin ro = 1'b1; val = m_cyc[31:0];  end
      12'hC80, 12'hC81: begin ro = 1'b1; val = m_cyc[63:32]; end
      12'hC02:          begin ro = 1'b1; val = m_ins[31:0];  end
      12'hC82:          begin ro = 1'b1; val = m_ins[63:32]; end
      default: hit = 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] upd(input logic [63:0] c, input bit inc, input bit wl,
                                      input bit wh, input logic [31:0] d);
    if (wl) return {c[63:32], d};
    if (wh) return {d, c[31:0] + 32'(inc)};
    return c + 64'(inc);
  endfunction

  // One request cycle: drive, predict, clock, then compare against the popped expectation.
  task automatic req(input logic [11:0] a, input bit rd, input bit wr, input logic [31:0] d,
                     input bit inc, output logic [31:0] obs);
    exp_t        e;
    bit          hit, ro, ill, wok;
    logic [31:0] val;
    bus.csr_addr_in    = a;
    bus.csr_rd_en_in   = rd;
    bus.csr_wr_en_in   = wr;
    bus.data_wr_in     = d;
    bus.instret_inc_in = inc;
    tb_decode(a, hit, ro, val);
    ill   = (rd || wr) && (!hit || (wr && ro));
    wok   = wr && !ill;
    e.v   = rd;
    e.ill = ill;
    e.d   = rd ? (ill ? 32'd0 : val) : m_dout;
    sb.push_back(e);
    m_dout = e.d;
    m_cyc  = upd(m_cyc, !m_inh[0], wok && a == 12'hB00, wok && a == 12'hB80, d);
    m_ins  = upd(m_ins, inc && !m_inh[2], wok && a == 12'hB02, wok && a == 12'hB82, d);
    if (wok && a == 12'h320) m_inh = d[2:0] & 3'b101;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("valid@%h", a),   {31'd0, bus.csr_rd_valid_out}, {31'd0, e.v});
    chk($sformatf("illegal@%h", a), {31'd0, bus.illegal_addr_out}, {31'd0, e.ill});
    chk($sformatf("data@%h", a),    bus.csr_data_out, e.d);
    $display("[TB] addr=%h rd=%0d wr=%0d wdata=%h inc=%0d -> data=%h valid=%0d illegal=%0d",
             a, rd, wr, d, inc, bus.csr_data_out, bus.csr_rd_valid_out, bus.illegal_addr_out);
    obs = bus.csr_data_out;
  endtask

  task automatic idle(input int n, input bit inc);
    logic [31:0] dummy;
    for (int i = 0; i < n; i++) req(12'h000, 1'b0, 1'b0, 32'd0, inc, dummy);
  endtask

  initial begin
    logic [31:0] obs;
    bus.csr_addr_in    = '0;
    bus.csr_rd_en_in   = 1'b0;
    bus.csr_wr_en_in   = 1'b0;
    bus.data_wr_in     = '0;
    bus.instret_inc_in = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_data",    bus.csr_data_out, 32'd0);
    chk("reset_valid",   {31'd0, bus.csr_rd_valid_out}, 32'd0);
    chk("reset_illegal", {31'd0, bus.illegal_addr_out}, 32'd0);
    rst = 1'b0;

    // Free-running count after reset.
    idle(10, 1'b0);
    req(12'hB00, 1, 0, 32'd0, 0, obs);               chk("plan_mcycle10", obs, 32'd10);

    // Low-to-high carry after half writes.
    req(12'hB80, 0, 1, 32'h0000_0001, 0, obs);
    req(12'hB00, 0, 1, 32'hFFFF_FFFF, 0, obs);
    idle(1, 1'b0);
    req(12'hB80, 1, 0, 32'd0, 0, obs);               chk("plan_carry_hi", obs, 32'd2);

    // Full 64-bit wrap.
    req(12'hB80, 0, 1, 32'hFFFF_FFFF, 0, obs);
    req(12'hB00, 0, 1, 32'hFFFF_FFFE, 0, obs);
    idle(3, 1'b0);
    req(12'hB00, 1, 0, 32'd0, 0, obs);               chk("plan_wrap_lo", obs, 32'd1);
    req(12'hB80, 1, 0, 32'd0, 0, obs);               chk("plan_wrap_hi", obs, 32'd0);

    // Inhibit: bit1 is not writable; both counters freeze.
    req(12'h320, 0, 1, 32'h0000_0007, 0, obs);
    idle(5, 1'b1);
    req(12'hB02, 1, 0, 32'd0, 0, obs);               chk("plan_inh_instret", obs, 32'd0);
    req(12'hB00, 1, 0, 32'd0, 0, obs);               chk("plan_inh_mcycle", obs, 32'd4);
    req(12'h320, 1, 0, 32'd0, 0, obs);               chk("plan_inh_read", obs, 32'd5);
    req(12'h320, 0, 1, 32'd0, 0, obs);
    idle(3, 1'b1);
    req(12'hB02, 1, 0, 32'd0, 0, obs);               chk("plan_instret3", obs, 32'd3);

    // Read-modify-write: old value returned, write beats the increment.
    req(12'hB02, 1, 1, 32'h0000_1234, 1, obs);       chk("plan_rmw_old", obs, 32'd3);
    req(12'hB02, 1, 0, 32'd0, 0, obs);               chk("plan_rmw_new", obs, 32'h1234);

    // Illegal accesses leave state untouched.
    req(12'hC00, 0, 1, 32'hFFFF_FFFF, 0, obs);
    req(12'h7C0, 1, 0, 32'd0, 0, obs);               chk("plan_illegal_data", obs, 32'd0);
    req(12'hC02, 1, 1, 32'h0000_DEAD, 0, obs);
    req(12'h123, 0, 1, 32'h0000_BEEF, 1, obs);
    req(12'hC02, 1, 0, 32'd0, 0, obs);               chk("plan_instret_kept", obs, 32'h1235);
    req(12'hC01, 1, 0, 32'd0, 0, obs);
    req(12'hC81, 1, 0, 32'd0, 0, obs);
    req(12'hC82, 1, 0, 32'd0, 0, obs);

    // Asynchronous reset with a read in flight.
    req(12'hB00, 1, 0, 32'd0, 0, obs);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_data",    bus.csr_data_out, 32'd0);
    chk("rst_async_valid",   {31'd0, bus.csr_rd_valid_out}, 32'd0);
    chk("rst_async_illegal", {31'd0, bus.illegal_addr_out}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", {31'd0, bus.csr_rd_valid_out}, 32'd0);
    bus.csr_rd_en_in = 1'b0;
    #2 rst = 1'b0;
    m_cyc = '0; m_ins = '0; m_inh = 3'b000; m_dout = '0;
    idle(2, 1'b0);
    req(12'hB00, 1, 0, 32'd0, 0, obs);               chk("rst_restart", obs, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
